fetch_ctrl: RTL



---
 rtl/fetch_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer that sits next to the program counter.
// It reads the PC off the shared bus into the MAR, performs a handshaked
// instruction-memory read, and presents the word to the decoder through a
// valid/ack instruction register. Jumps are queued and delivered to the PC
// by driving the target onto the bus together with pc_load.
module fetch_ctrl #(
  parameter int N       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  output logic         pc_valid,
  output logic         pc_inc,
  output logic         pc_load,
  input  logic [N-1:0] bus_in,
  output logic [N-1:0] bus_out,
  output logic         bus_oe,
  output logic [N-1:0] mem_addr,
  output logic         mem_rd,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic [N-1:0] ir,
  output logic         ir_valid,
  input  logic         ir_ack,
  input  logic         jump_req,
  input  logic [N-1:0] jump_target,
  input  logic         halt,
  output logic         fetch_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    READ = 3'd2,
    HOLD = 3'd3,
    JUMP = 3'd4
  } state_t;

  // Last READ cycle index that may still wait; reaching it without
  // mem_ready means the TIMEOUT-th wait cycle has elapsed.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t       state_r;
  state_t       state_s;
  logic [N-1:0] mar_r;
  logic [N-1:0] ir_r;
  logic [N-1:0] jump_tgt_r;
  logic         jump_pend_r;
  logic [7:0]   wait_cnt_r;
  logic         fetch_err_r;
  logic         first_hold_r;
  logic         timeout_s;

  // Next-state decode; the timeout strobe is raised only on the final wait cycle.
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (fetch_err_r) begin
          state_s = IDLE;
        end else if (jump_pend_r) begin
          state_s = JUMP;
        end else if (!halt) begin
          state_s = ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        state_s = READ;
      end
      READ: begin
        // A late mem_ready on the last allowed cycle still wins over the timeout.
        if (mem_ready) begin
          state_s = HOLD;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_s   = IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = READ;
        end
      end
      HOLD: begin
        if (!ir_ack) begin
          state_s = HOLD;
        end else if (jump_pend_r) begin
          state_s = JUMP;
        end else if (halt) begin
          state_s = IDLE;
        end else begin
          state_s = ADDR;
        end
      end
      JUMP: begin
        if (halt) begin
          state_s = IDLE;
        end else begin
          state_s = ADDR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Fetch datapath: MAR capture, instruction capture, wait counter, first-HOLD marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      mar_r        <= {N{1'b0}};
      ir_r         <= {N{1'b0}};
      wait_cnt_r   <= 8'd0;
      first_hold_r <= 1'b0;
    end else begin
      if (state_r == ADDR) begin
        mar_r <= bus_in;
      end
      if ((state_r == READ) && mem_ready) begin
        ir_r <= mem_rdata;
      end
      if ((state_r == READ) && !mem_ready) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= 8'd0;
      end
      first_hold_r <= (state_r == READ) && mem_ready;
    end
  end

  // Jump capture: a new request always wins, so one arriving during JUMP stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      jump_pend_r <= 1'b0;
      jump_tgt_r  <= {N{1'b0}};
    end else if (jump_req) begin
      jump_pend_r <= 1'b1;
      jump_tgt_r  <= jump_target;
    end else if (state_r == JUMP) begin
      jump_pend_r <= 1'b0;
    end
  end

  // Sticky memory-timeout flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_err_r <= 1'b0;
    end else if (timeout_s) begin
      fetch_err_r <= 1'b1;
    end
  end

  // Outputs decode purely from registered state; JUMP and ADDR are exclusive,
  // so bus_oe and pc_valid can never be high together.
  assign pc_valid  = (state_r == ADDR);
  assign pc_inc    = first_hold_r;
  assign pc_load   = (state_r == JUMP);
  assign bus_oe    = (state_r == JUMP);
  assign bus_out   = (state_r == JUMP) ? jump_tgt_r : {N{1'b0}};
  assign mem_addr  = mar_r;
  assign mem_rd    = (state_r == READ);
  assign ir        = ir_r;
  assign ir_valid  = (state_r == HOLD);
  assign fetch_err = fetch_err_r;

endmodule
